// File: rtl/tmds_decoder.sv
// TMDS receive decoder: finds bit alignment from control-token runs, then decodes tokens and video data.
// Define TMDS_DECODER_MANUAL_SLIP_EN to add a manual bit-slip input.
module tmds_decoder #(
  parameter int unsigned SEARCH_WINDOW   = 1024,
  parameter int unsigned CTRL_LOCK_COUNT = 8,
  parameter int unsigned LOSS_WINDOW     = 2048
) (
  input  logic       pixclk,
  input  logic       rst,
`ifdef TMDS_DECODER_MANUAL_SLIP_EN
  input  logic       slip,
`endif
  input  logic [9:0] din,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] slip_offset
);

  localparam int unsigned SYM_W      = 10;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned RUN_W      = $clog2(CTRL_LOCK_COUNT + 1);
  localparam int unsigned MAX_OFFSET = 9;

  localparam logic [SYM_W-1:0] TOK_CD0 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOK_CD1 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOK_CD2 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOK_CD3 = 10'b1010101011;

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RUN_W-1:0]   run, run_d, run_inc;
  logic [OFF_W-1:0]   off_d, off_inc;
  logic [SYM_W-1:0]   prev, sym;
  logic [2*SYM_W-1:0] window;
  logic               is_tok;
  logic [1:0]         tok_cd;
  logic [7:0]         dmask, dec;
  logic [7:0]         vd_d;
  logic [1:0]         cd_d;
  logic               vde_d, locked_d;

  // Stage 1: previous word plus current word, barrel-selected at the current offset
  always_comb window = {din, prev};

  always_ff @(posedge pixclk) begin
    if (rst) begin
      prev <= '0;
      sym  <= '0;
    end else begin
      prev <= din;
      sym  <= SYM_W'(window >> slip_offset);
    end
  end

  // Token classification and data-symbol decode on the aligned symbol
  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (sym)
      TOK_CD0: tok_cd = 2'b00;
      TOK_CD1: tok_cd = 2'b01;
      TOK_CD2: tok_cd = 2'b10;
      TOK_CD3: tok_cd = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  always_comb begin
    dmask  = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = '0;
    dec[0] = dmask[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (dmask[i] ^ dmask[i-1]) : ~(dmask[i] ^ dmask[i-1]);
    end
  end

  // Alignment FSM state register
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state       <= ST_SEARCH;
      cnt         <= '0;
      run         <= '0;
      slip_offset <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      run         <= run_d;
      slip_offset <= off_d;
    end
  end

  always_comb begin
    off_inc = (slip_offset == OFF_W'(MAX_OFFSET)) ? '0 : slip_offset + OFF_W'(1);
    run_inc = run + RUN_W'(1);
  end

  // Next-state: search slips every SEARCH_WINDOW token-free cycles, verify needs an unbroken run
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    run_d   = run;
    off_d   = slip_offset;
    case (state)
      ST_SEARCH: begin
        if (is_tok) begin
          cnt_d   = '0;
          run_d   = RUN_W'(1);
          state_d = (CTRL_LOCK_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
        end else if (cnt == CNT_W'(SEARCH_WINDOW - 1)) begin
          cnt_d = '0;
          off_d = off_inc;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_VERIFY: begin
        if (is_tok) begin
          run_d = run_inc;
          if (run_inc >= RUN_W'(CTRL_LOCK_COUNT)) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
          run_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          cnt_d = '0;
        end else if (cnt == CNT_W'(LOSS_WINDOW - 1)) begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
          run_d   = '0;
          off_d   = off_inc;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        cnt_d   = '0;
        run_d   = '0;
      end
    endcase
`ifdef TMDS_DECODER_MANUAL_SLIP_EN
    if (slip) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
      run_d   = '0;
      off_d   = off_inc;
    end
`endif
  end

  // Output decode: everything held at zero until aligned; cd keeps its value across data
  always_comb begin
    vd_d     = '0;
    cd_d     = '0;
    vde_d    = 1'b0;
    locked_d = 1'b0;
    if (state == ST_LOCKED) begin
      locked_d = 1'b1;
      if (is_tok) begin
        cd_d = tok_cd;
      end else begin
        vde_d = 1'b1;
        vd_d  = dec;
        cd_d  = cd;
      end
    end
  end

  // Stage 2 output registers
  always_ff @(posedge pixclk) begin
    if (rst) begin
      vd     <= '0;
      cd     <= '0;
      vde    <= 1'b0;
      locked <= 1'b0;
    end else begin
      vd     <= vd_d;
      cd     <= cd_d;
      vde    <= vde_d;
      locked <= locked_d;
    end
  end

endmodule
